// File: rtl/tc_pl_cap_pkg.sv
// Shared types and constants for the multi-gain capture sequencer.
// Holds the FSM state enum, the command codes and the status bundle.
package tc_pl_cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    TRIG,
    WAIT,
    NEXT,
    DONE
  } cap_state_e;

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_ABORT = 2'b10;

  typedef struct packed {
    logic busy;
    logic done;
  } cap_sts_t;

  function automatic logic gain_num_ok(
    input int unsigned gn,
    input int unsigned ngain
  );
    return (gn != 0) && (gn <= ngain);
  endfunction

endpackage

// File: rtl/tc_pl_cap_shadow.sv
// Per-gain shadow copy of the capture config, loaded once per run.
// Ports: clk125/rst, load strobe, flat cfg_* buses in, rd_idx-selected
// drive words out, plus the settle count of gain ld_idx.
module tc_pl_cap_shadow
  import tc_pl_cap_pkg::*;
#(
  parameter int unsigned NGAIN = 4,
  parameter int unsigned GN_W  = 3,
  parameter int unsigned CYC_W = 18,
  parameter int unsigned DEL_W = 32,
  parameter int unsigned DAC_W = 32,
  parameter int unsigned LMH_W = 6,
  parameter int unsigned RLY_W = 4
) (
  input  logic                   clk125,
  input  logic                   rst,
  input  logic                   load,
  input  logic [NGAIN*CYC_W-1:0] cfg_cycle,
  input  logic [NGAIN*DEL_W-1:0] cfg_lddel,
  input  logic [NGAIN*DAC_W-1:0] cfg_dacA,
  input  logic [NGAIN*DAC_W-1:0] cfg_dacB,
  input  logic [NGAIN*LMH_W-1:0] cfg_lmh,
  input  logic [NGAIN*RLY_W-1:0] cfg_relay,
  input  logic [GN_W-1:0]        rd_idx,
  input  logic [GN_W-1:0]        ld_idx,
  output logic [CYC_W-1:0]       rd_cycle,
  output logic [DAC_W-1:0]       rd_dacA,
  output logic [DAC_W-1:0]       rd_dacB,
  output logic [LMH_W-1:0]       rd_lmh,
  output logic [RLY_W-1:0]       rd_relay,
  output logic [DEL_W-1:0]       ld_lddel
);

  logic [NGAIN*CYC_W-1:0] sh_cycle;
  logic [NGAIN*DEL_W-1:0] sh_lddel;
  logic [NGAIN*DAC_W-1:0] sh_dacA;
  logic [NGAIN*DAC_W-1:0] sh_dacB;
  logic [NGAIN*LMH_W-1:0] sh_lmh;
  logic [NGAIN*RLY_W-1:0] sh_relay;

  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) begin
      sh_cycle <= '0;
      sh_lddel <= '0;
      sh_dacA  <= '0;
      sh_dacB  <= '0;
      sh_lmh   <= '0;
      sh_relay <= '0;
    end else if (load) begin
      sh_cycle <= cfg_cycle;
      sh_lddel <= cfg_lddel;
      sh_dacA  <= cfg_dacA;
      sh_dacB  <= cfg_dacB;
      sh_lmh   <= cfg_lmh;
      sh_relay <= cfg_relay;
    end
  end

  // Compare-based mux: GN_W may be wider than the entry count,
  // out-of-range indices read as zero.
  always_comb begin
    rd_cycle = '0;
    rd_dacA  = '0;
    rd_dacB  = '0;
    rd_lmh   = '0;
    rd_relay = '0;
    ld_lddel = '0;
    for (int i = 0; i < int'(NGAIN); i++) begin
      if (rd_idx == GN_W'(i)) begin
        rd_cycle = sh_cycle[i*CYC_W +: CYC_W];
        rd_dacA  = sh_dacA[i*DAC_W +: DAC_W];
        rd_dacB  = sh_dacB[i*DAC_W +: DAC_W];
        rd_lmh   = sh_lmh[i*LMH_W +: LMH_W];
        rd_relay = sh_relay[i*RLY_W +: RLY_W];
      end
      if (ld_idx == GN_W'(i)) begin
        ld_lddel = sh_lddel[i*DEL_W +: DEL_W];
      end
    end
  end

endmodule

// File: rtl/tc_pl_cap_seq_gp.sv
// Multi-gain capture sequencer: shadows per-gain config on start, then
// steps each gain through settle / trigger / wait-for-complete.
// Ports: clk125, rst (async, low), cmd_wr/cmd_code from the GP bank,
// cfg_* per-gain config, cap_cing/cap_cmpt from the capture engine,
// cap_* drive words and trigger, sts {busy,done}, sts_err, cap_time,
// cap_irq. Optional CAP_SEQ_TIMEOUT_EN adds a cmpt watchdog (cfg_tmo).
module tc_pl_cap_seq_gp
  import tc_pl_cap_pkg::*;
#(
  parameter int unsigned NGAIN = 4,
  parameter int unsigned GN_W  = 3,
  parameter int unsigned CYC_W = 18,
  parameter int unsigned DEL_W = 32,
  parameter int unsigned DAC_W = 32,
  parameter int unsigned LMH_W = 6,
  parameter int unsigned RLY_W = 4,
  parameter int unsigned TM_W  = 32
) (
  input  logic                   clk125,
  input  logic                   rst,
  input  logic                   cmd_wr,
  input  logic [1:0]             cmd_code,
  input  logic [GN_W-1:0]        cfg_gain_num,
  input  logic [NGAIN*CYC_W-1:0] cfg_cycle,
  input  logic [NGAIN*DEL_W-1:0] cfg_lddel,
  input  logic [NGAIN*DAC_W-1:0] cfg_dacA,
  input  logic [NGAIN*DAC_W-1:0] cfg_dacB,
  input  logic [NGAIN*LMH_W-1:0] cfg_lmh,
  input  logic [NGAIN*RLY_W-1:0] cfg_relay,
  input  logic [TM_W-1:0]        cfg_tmo,
  input  logic                   cap_cing,
  input  logic                   cap_cmpt,
  output logic                   cap_trig,
  output logic [GN_W-1:0]        cap_gain_idx,
  output logic [CYC_W-1:0]       cap_cycle,
  output logic [DAC_W-1:0]       cap_dacA,
  output logic [DAC_W-1:0]       cap_dacB,
  output logic [LMH_W-1:0]       cap_lmh,
  output logic [RLY_W-1:0]       cap_relay,
  output logic [1:0]             sts,
  output logic                   sts_err,
  output logic [TM_W-1:0]        cap_time,
  output logic                   cap_irq
);

  cap_state_e state;
  cap_state_e nxt;

  logic            is_start;
  logic            is_abort;
  logic            abort_go;
  logic            gn_ok;
  logic            last;
  logic            tmo_fire;
  logic            busy;
  logic            done;
  logic            err;
  logic            irq;
  logic            out_en;
  logic [GN_W-1:0] idx;
  logic [GN_W-1:0] nxt_idx;
  logic [GN_W-1:0] sh_gn;
  logic [DEL_W-1:0] set_cnt;
  logic [DEL_W-1:0] ld_lddel;
  cap_sts_t        st;

  logic [CYC_W-1:0] sh_cycle;
  logic [DAC_W-1:0] sh_dacA;
  logic [DAC_W-1:0] sh_dacB;
  logic [LMH_W-1:0] sh_lmh;
  logic [RLY_W-1:0] sh_relay;

  always_comb begin
    is_start = 1'b0;
    is_abort = 1'b0;
    if (cmd_wr) begin
      unique case (1'b1)
        (cmd_code == CMD_START): is_start = 1'b1;
        (cmd_code == CMD_ABORT): is_abort = 1'b1;
        default: ;
      endcase
    end
  end

  assign abort_go = is_abort && (state != IDLE);
  assign gn_ok    = gain_num_ok(32'(cfg_gain_num), NGAIN);
  assign nxt_idx  = idx + GN_W'(1);
  assign last     = (nxt_idx == sh_gn);

  tc_pl_cap_shadow #(
    .NGAIN (NGAIN),
    .GN_W  (GN_W),
    .CYC_W (CYC_W),
    .DEL_W (DEL_W),
    .DAC_W (DAC_W),
    .LMH_W (LMH_W),
    .RLY_W (RLY_W)
  ) u_shadow (
    .clk125    (clk125),
    .rst       (rst),
    .load      (state == LOAD),
    .cfg_cycle (cfg_cycle),
    .cfg_lddel (cfg_lddel),
    .cfg_dacA  (cfg_dacA),
    .cfg_dacB  (cfg_dacB),
    .cfg_lmh   (cfg_lmh),
    .cfg_relay (cfg_relay),
    .rd_idx    (idx),
    .ld_idx    (nxt_idx),
    .rd_cycle  (sh_cycle),
    .rd_dacA   (sh_dacA),
    .rd_dacB   (sh_dacB),
    .rd_lmh    (sh_lmh),
    .rd_relay  (sh_relay),
    .ld_lddel  (ld_lddel)
  );

`ifdef CAP_SEQ_TIMEOUT_EN
  logic [TM_W-1:0] sh_tmo;
  logic [TM_W-1:0] tmo_cnt;

  // Watchdog spans TRIG and WAIT so the error lands cfg_tmo
  // cycles after the trigger pulse.
  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) begin
      sh_tmo  <= '0;
      tmo_cnt <= '0;
    end else begin
      if (state == LOAD) begin
        sh_tmo <= cfg_tmo;
      end
      if (state == SETTLE && set_cnt == '0) begin
        tmo_cnt <= sh_tmo;
      end else if ((state == TRIG || state == WAIT) &&
                   tmo_cnt != '0) begin
        tmo_cnt <= tmo_cnt - TM_W'(1);
      end
    end
  end

  assign tmo_fire = (state == WAIT) && (sh_tmo != '0) &&
                    (tmo_cnt <= TM_W'(1)) && !cap_cmpt;
`else
  logic unused_tmo;
  assign unused_tmo = ^cfg_tmo;
  assign tmo_fire   = 1'b0;
`endif

  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    if (abort_go) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_start && !cap_cing && gn_ok) nxt = LOAD;
        end
        LOAD: nxt = SETTLE;
        SETTLE: begin
          if (set_cnt == '0) nxt = TRIG;
        end
        // cmpt arriving alongside the trigger is taken here.
        TRIG: nxt = cap_cmpt ? NEXT : WAIT;
        WAIT: begin
          if (cap_cmpt) nxt = NEXT;
          else if (tmo_fire) nxt = IDLE;
        end
        NEXT: nxt = last ? DONE : SETTLE;
        DONE: nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk125 or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      irq      <= 1'b0;
      out_en   <= 1'b0;
      idx      <= '0;
      sh_gn    <= '0;
      set_cnt  <= '0;
      cap_time <= '0;
    end else begin
      irq <= 1'b0;
      if (busy && cap_time != '1) begin
        cap_time <= cap_time + TM_W'(1);
      end
      if (abort_go) begin
        busy   <= 1'b0;
        done   <= 1'b0;
        out_en <= 1'b0;
        idx    <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (is_start && !cap_cing && !gn_ok) begin
              err <= 1'b1;
              irq <= 1'b1;
            end
          end
          LOAD: begin
            sh_gn    <= cfg_gain_num;
            idx      <= '0;
            set_cnt  <= cfg_lddel[DEL_W-1:0];
            cap_time <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            out_en   <= 1'b1;
          end
          SETTLE: begin
            if (set_cnt != '0) begin
              set_cnt <= set_cnt - DEL_W'(1);
            end
          end
          WAIT: begin
            if (tmo_fire) begin
              err    <= 1'b1;
              irq    <= 1'b1;
              busy   <= 1'b0;
              out_en <= 1'b0;
              idx    <= '0;
            end
          end
          // Status moves here so DONE shows busy=0/done=1/irq.
          NEXT: begin
            if (last) begin
              busy <= 1'b0;
              done <= 1'b1;
              irq  <= 1'b1;
            end else begin
              idx     <= nxt_idx;
              set_cnt <= ld_lddel;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Drive words hold the last gain after DONE; cleared by
  // abort, watchdog or reset.
  always_comb begin
    cap_trig     = (state == TRIG);
    cap_gain_idx = '0;
    cap_cycle    = '0;
    cap_dacA     = '0;
    cap_dacB     = '0;
    cap_lmh      = '0;
    cap_relay    = '0;
    if (out_en) begin
      cap_gain_idx = idx;
      cap_cycle    = sh_cycle;
      cap_dacA     = sh_dacA;
      cap_dacB     = sh_dacB;
      cap_lmh      = sh_lmh;
      cap_relay    = sh_relay;
    end
    st.busy = busy;
    st.done = done;
  end

  assign sts     = st;
  assign sts_err = err;
  assign cap_irq = irq;

endmodule

// File: tb/tb_tc_pl_cap_seq_gp.sv
// Directed bench for tc_pl_cap_seq_gp.
// Build with CAP_SEQ_TIMEOUT_EN to include the watchdog case.
module tb_tc_pl_cap_seq_gp;

  localparam int NGAIN = 4;
  localparam int GN_W  = 3;
  localparam int CYC_W = 18;
  localparam int DEL_W = 32;
  localparam int DAC_W = 32;
  localparam int LMH_W = 6;
  localparam int RLY_W = 4;
  localparam int TM_W  = 32;

  logic                   clk125 = 1'b0;
  logic                   rst;
  logic                   cmd_wr;
  logic [1:0]             cmd_code;
  logic [GN_W-1:0]        cfg_gain_num;
  logic [NGAIN*CYC_W-1:0] cfg_cycle;
  logic [NGAIN*DEL_W-1:0] cfg_lddel;
  logic [NGAIN*DAC_W-1:0] cfg_dacA;
  logic [NGAIN*DAC_W-1:0] cfg_dacB;
  logic [NGAIN*LMH_W-1:0] cfg_lmh;
  logic [NGAIN*RLY_W-1:0] cfg_relay;
  logic [TM_W-1:0]        cfg_tmo;
  logic                   cap_cing;
  logic                   cap_cmpt;
  logic                   cap_trig;
  logic [GN_W-1:0]        cap_gain_idx;
  logic [CYC_W-1:0]       cap_cycle;
  logic [DAC_W-1:0]       cap_dacA;
  logic [DAC_W-1:0]       cap_dacB;
  logic [LMH_W-1:0]       cap_lmh;
  logic [RLY_W-1:0]       cap_relay;
  logic [1:0]             sts;
  logic                   sts_err;
  logic [TM_W-1:0]        cap_time;
  logic                   cap_irq;

  logic resp_en  = 1'b0;
  logic resp_cmpt = 1'b0;
  logic man_cmpt = 1'b0;
  assign cap_cmpt = resp_cmpt | man_cmpt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int trig_n = 0;
  int irq_n = 0;
  int irq_cyc = 0;
  int trig_cyc [16];
  logic [GN_W-1:0]  trig_idx [16];
  logic [DAC_W-1:0] trig_dac [16];

  tc_pl_cap_seq_gp dut (
    .clk125       (clk125),
    .rst          (rst),
    .cmd_wr       (cmd_wr),
    .cmd_code     (cmd_code),
    .cfg_gain_num (cfg_gain_num),
    .cfg_cycle    (cfg_cycle),
    .cfg_lddel    (cfg_lddel),
    .cfg_dacA     (cfg_dacA),
    .cfg_dacB     (cfg_dacB),
    .cfg_lmh      (cfg_lmh),
    .cfg_relay    (cfg_relay),
    .cfg_tmo      (cfg_tmo),
    .cap_cing     (cap_cing),
    .cap_cmpt     (cap_cmpt),
    .cap_trig     (cap_trig),
    .cap_gain_idx (cap_gain_idx),
    .cap_cycle    (cap_cycle),
    .cap_dacA     (cap_dacA),
    .cap_dacB     (cap_dacB),
    .cap_lmh      (cap_lmh),
    .cap_relay    (cap_relay),
    .sts          (sts),
    .sts_err      (sts_err),
    .cap_time     (cap_time),
    .cap_irq      (cap_irq)
  );

  always #4 clk125 = ~clk125;

  always @(posedge clk125) cyc <= cyc + 1;

  always @(negedge clk125) begin
    if (cap_trig && trig_n < 16) begin
      trig_idx[trig_n] <= cap_gain_idx;
      trig_dac[trig_n] <= cap_dacA;
      trig_cyc[trig_n] <= cyc;
      trig_n <= trig_n + 1;
    end
    if (cap_irq) begin
      irq_n <= irq_n + 1;
      irq_cyc <= cyc;
    end
  end

  // Capture-engine model: cmpt 4 cycles after each trigger.
  initial begin
    forever begin
      @(negedge clk125);
      if (resp_en && cap_trig) begin
        repeat (4) @(posedge clk125);
        #1 resp_cmpt = 1'b1;
        @(posedge clk125);
        #1 resp_cmpt = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk125);
    #1;
  endtask

  task automatic cmd(input logic [1:0] code);
    cmd_wr = 1'b1;
    cmd_code = code;
    tick(1);
    cmd_wr = 1'b0;
    cmd_code = 2'b00;
  endtask

  task automatic set_cfg(input int gn, input int l0, input int l1,
                         input int l2, input int l3);
    int ld [4];
    ld = '{l0, l1, l2, l3};
    cfg_gain_num = GN_W'(gn);
    for (int i = 0; i < NGAIN; i++) begin
      cfg_lddel[i*DEL_W +: DEL_W] = DEL_W'(ld[i]);
      cfg_cycle[i*CYC_W +: CYC_W] = CYC_W'(100 * i + 10);
      cfg_dacA[i*DAC_W +: DAC_W]  = 32'hA000_0000 + 32'(i);
      cfg_dacB[i*DAC_W +: DAC_W]  = 32'hB000_0000 + 32'(i);
      cfg_lmh[i*LMH_W +: LMH_W]   = LMH_W'(i + 1);
      cfg_relay[i*RLY_W +: RLY_W] = RLY_W'(i + 5);
    end
  endtask

  task automatic wait_done(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk125);
      if (sts == 2'b01) begin
        ok = 1'b1;
        break;
      end
    end
    tick(1);
  endtask

  task automatic wait_trig(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk125);
      if (cap_trig) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic ok;
    int b;
    int s;
    int ib;

    rst = 1'b0;
    cmd_wr = 1'b0;
    cmd_code = 2'b00;
    cap_cing = 1'b0;
    cfg_tmo = '0;
    cfg_cycle = '0;
    cfg_lddel = '0;
    cfg_dacA = '0;
    cfg_dacB = '0;
    cfg_lmh = '0;
    cfg_relay = '0;
    set_cfg(3, 5, 0, 2, 7);
    #20;
    chk("rst_sts", sts, 2'b00);
    chk("rst_err", sts_err, 1'b0);
    chk("rst_time", cap_time, 0);
    chk("rst_trig", cap_trig, 1'b0);
    chk("rst_dacA", cap_dacA, 0);
    @(negedge clk125);
    rst = 1'b1;
    tick(2);

    // Three-gain run; config scribbled mid-run, extra start ignored.
    resp_en = 1'b1;
    b = trig_n;
    ib = irq_n;
    s = cyc;
    cmd(2'b01);
    wait_trig(40, ok);
    chk("t1_trig0_seen", ok, 1'b1);
    tick(1);
    for (int i = 0; i < NGAIN; i++)
      cfg_dacA[i*DAC_W +: DAC_W] = 32'hFFFF_FFFF;
    cfg_lddel = '1;
    cfg_gain_num = 3'd1;
    cmd(2'b01);
    wait_done(200, ok);
    chk("t1_done_seen", ok, 1'b1);
    chk("t1_ntrig", trig_n - b, 3);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t1_idx%0d", k), trig_idx[b+k], GN_W'(k));
      chk($sformatf("t1_dac%0d", k), trig_dac[b+k],
          32'hA000_0000 + 32'(k));
    end
    chk("t1_lat0", trig_cyc[b] - s, 8);
    chk("t1_lat1", trig_cyc[b+1] - trig_cyc[b], 7);
    chk("t1_lat2", trig_cyc[b+2] - trig_cyc[b+1], 9);
    chk("t1_sts", sts, 2'b01);
    chk("t1_time", cap_time, 28);
    chk("t1_irq", irq_n - ib, 1);
    chk("t1_err", sts_err, 1'b0);
    chk("t1_hold_dac", cap_dacA, 32'hA000_0002);
    chk("t1_hold_cyc", cap_cycle, 210);
    tick(5);
    chk("t1_done_held", sts, 2'b01);
    chk("t1_time_held", cap_time, 28);
    resp_en = 1'b0;

    // Bad gain_num: zero and above NGAIN.
    b = trig_n;
    ib = irq_n;
    cfg_gain_num = 3'd0;
    cmd(2'b01);
    tick(3);
    chk("t2_err0", sts_err, 1'b1);
    chk("t2_irq0", irq_n - ib, 1);
    chk("t2_busy0", sts[1], 1'b0);
    cfg_gain_num = 3'd5;
    cmd(2'b01);
    tick(3);
    chk("t2_irq5", irq_n - ib, 2);
    chk("t2_busy5", sts[1], 1'b0);
    chk("t2_notrig", trig_n - b, 0);

    // Start while the engine is busy is ignored.
    set_cfg(1, 0, 0, 0, 0);
    cap_cing = 1'b1;
    cmd(2'b01);
    tick(3);
    chk("t_cing_busy", sts[1], 1'b0);
    chk("t_cing_notrig", trig_n - b, 0);
    cap_cing = 1'b0;

    // Abort in WAIT together with cmpt.
    set_cfg(2, 1, 1, 1, 1);
    b = trig_n;
    ib = irq_n;
    cmd(2'b01);
    wait_trig(40, ok);
    chk("t4_trig_seen", ok, 1'b1);
    tick(1);
    cmd_wr = 1'b1;
    cmd_code = 2'b10;
    man_cmpt = 1'b1;
    tick(1);
    cmd_wr = 1'b0;
    cmd_code = 2'b00;
    man_cmpt = 1'b0;
    @(negedge clk125);
    chk("t4_sts", sts, 2'b00);
    chk("t4_dacA", cap_dacA, 0);
    chk("t4_dacB", cap_dacB, 0);
    chk("t4_lmh", cap_lmh, 0);
    chk("t4_relay", cap_relay, 0);
    chk("t4_cycle", cap_cycle, 0);
    tick(8);
    chk("t4_noirq", irq_n - ib, 0);
    chk("t4_ntrig", trig_n - b, 1);

    // Reset mid-SETTLE, then a clean restart.
    set_cfg(1, 20, 0, 0, 0);
    cmd(2'b01);
    tick(3);
    rst = 1'b0;
    #1;
    chk("t6_rst_sts", sts, 2'b00);
    chk("t6_rst_time", cap_time, 0);
    chk("t6_rst_dac", cap_dacA, 0);
    @(negedge clk125);
    rst = 1'b1;
    tick(1);
    set_cfg(1, 0, 0, 0, 0);
    resp_en = 1'b1;
    b = trig_n;
    ib = irq_n;
    cmd(2'b01);
    wait_done(100, ok);
    chk("t6_done_seen", ok, 1'b1);
    chk("t6_time", cap_time, 7);
    chk("t6_ntrig", trig_n - b, 1);
    chk("t6_irq", irq_n - ib, 1);
    resp_en = 1'b0;

`ifdef CAP_SEQ_TIMEOUT_EN
    // Watchdog: no cmpt, error 10 cycles after the trigger.
    set_cfg(1, 0, 0, 0, 0);
    cfg_tmo = 32'd10;
    b = trig_n;
    cmd(2'b01);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk125);
      if (cap_irq) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t5_irq_seen", ok, 1'b1);
    tick(1);
    chk("t5_delay", irq_cyc - trig_cyc[b], 10);
    chk("t5_err", sts_err, 1'b1);
    chk("t5_sts", sts, 2'b00);
    chk("t5_dac", cap_dacA, 0);
    cfg_tmo = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
